rv32_decode_stage: RTL and testbench

Instruction-decode stage of the 5-stage RV32I core: sits between the IF/ID boundary and the EX stage, and directly upstream of the register file. It drives the register-file read selects combinationally, so the file's registered read data lands in the same cycle as this block's registered ID/EX control outputs. It decodes RV32I base instructions, generates immediates, detects load-use hazards (inserting one bubble), and handles downstream stall and branch flush.

---
 rtl/rv32_decode_stage_if.sv | 40 ++++
 rtl/rv32_decode_stage.sv | 216 +++++++++++++++++++++
 tb/tb_rv32_decode_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_decode_stage_if.sv
// IF/ID-to-EX bus of the RV32I decode stage: fetch inputs, stall/flush
// controls, register-file read selects and the registered ID/EX payload.
interface rv32_decode_stage_if;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        stall_in;
   logic        flush;
   logic [4:0]  rf_sel_s1;
   logic [4:0]  rf_sel_s2;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_instr;
   logic [4:0]  ex_rd;
   logic [31:0] ex_imm;
   logic [3:0]  ex_alu_op;
   logic        ex_alu_src_imm;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_branch;
   logic        ex_jump;
   logic        ex_illegal;
   logic [31:0] perf_bubbles;

   modport master (
      output if_valid, if_instr, if_pc, stall_in, flush,
      input  id_ready, rf_sel_s1, rf_sel_s2, ex_valid, ex_pc, ex_instr, ex_rd,
             ex_imm, ex_alu_op, ex_alu_src_imm, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_branch, ex_jump, ex_illegal, perf_bubbles
   );

   modport slave (
      input  if_valid, if_instr, if_pc, stall_in, flush,
      output id_ready, rf_sel_s1, rf_sel_s2, ex_valid, ex_pc, ex_instr, ex_rd,
             ex_imm, ex_alu_op, ex_alu_src_imm, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_branch, ex_jump, ex_illegal, perf_bubbles
   );
endinterface

// File: rtl/rv32_decode_stage.sv
// RV32I instruction-decode stage: decode, immediate generation, load-use
// bubble insertion, downstream stall hold and branch flush.
module rv32_decode_stage (
   input  logic                 clk,
   input  logic                 rst,
   rv32_decode_stage_if.slave   bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned OP_W  = 4;
   localparam logic [XLEN-1:0] RESET_INSTR = 32'h0000_0013;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic             r_ex_valid;
   logic [XLEN-1:0]  r_ex_pc;
   logic [XLEN-1:0]  r_ex_instr;
   logic [REG_W-1:0] r_ex_rd;
   logic [XLEN-1:0]  r_ex_imm;
   logic [OP_W-1:0]  r_ex_alu_op;
   logic             r_ex_alu_src_imm;
   logic             r_ex_reg_write;
   logic             r_ex_mem_read;
   logic             r_ex_mem_write;
   logic             r_ex_branch;
   logic             r_ex_jump;
   logic             r_ex_illegal;
   logic [XLEN-1:0]  r_perf_bubbles;

   logic [6:0]       w_opc;
   logic [2:0]       w_funct3;
   logic [REG_W-1:0] w_rs1;
   logic [REG_W-1:0] w_rs2;
   logic [REG_W-1:0] w_rd;
   logic [XLEN-1:0]  w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [XLEN-1:0]  w_imm;
   logic [OP_W-1:0]  w_alu_op;
   logic             w_alu_src_imm, w_reg_write, w_mem_read, w_mem_write;
   logic             w_branch, w_jump, w_illegal;
   logic             w_uses_rs1, w_uses_rs2;
   logic             w_hazard;
   logic             w_take;
   logic             w_sel_hold;
   logic             w_id_ready;

   assign w_opc    = bus.if_instr[6:0];
   assign w_funct3 = bus.if_instr[14:12];
   assign w_rs1    = bus.if_instr[19:15];
   assign w_rs2    = bus.if_instr[24:20];

   assign w_imm_i = {{20{bus.if_instr[31]}}, bus.if_instr[31:20]};
   assign w_imm_s = {{20{bus.if_instr[31]}}, bus.if_instr[31:25], bus.if_instr[11:7]};
   assign w_imm_b = {{20{bus.if_instr[31]}}, bus.if_instr[7], bus.if_instr[30:25],
                     bus.if_instr[11:8], 1'b0};
   assign w_imm_u = {bus.if_instr[31:12], 12'b0};
   assign w_imm_j = {{12{bus.if_instr[31]}}, bus.if_instr[19:12], bus.if_instr[20],
                     bus.if_instr[30:21], 1'b0};

   // Opcode decode of the instruction currently offered by IF
   always_comb begin
      w_imm         = '0;
      w_alu_op      = '0;
      w_alu_src_imm = 1'b0;
      w_reg_write   = 1'b0;
      w_mem_read    = 1'b0;
      w_mem_write   = 1'b0;
      w_branch      = 1'b0;
      w_jump        = 1'b0;
      w_illegal     = 1'b0;
      w_uses_rs1    = 1'b0;
      w_uses_rs2    = 1'b0;
      case (w_opc)
         OPC_LUI, OPC_AUIPC: w_imm = w_imm_u;
         OPC_JAL: begin
            w_imm       = w_imm_j;
            w_jump      = 1'b1;
            w_reg_write = 1'b1;
         end
         OPC_JALR: begin
            w_imm       = w_imm_i;
            w_jump      = 1'b1;
            w_reg_write = 1'b1;
            w_uses_rs1  = 1'b1;
         end
         OPC_BRANCH: begin
            w_imm      = w_imm_b;
            w_branch   = 1'b1;
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
         end
         OPC_LOAD: begin
            w_imm       = w_imm_i;
            w_mem_read  = 1'b1;
            w_reg_write = 1'b1;
            w_uses_rs1  = 1'b1;
         end
         OPC_STORE: begin
            w_imm       = w_imm_s;
            w_mem_write = 1'b1;
            w_uses_rs1  = 1'b1;
            w_uses_rs2  = 1'b1;
         end
         OPC_OP_IMM: begin
            w_imm         = w_imm_i;
            w_alu_src_imm = 1'b1;
            w_reg_write   = 1'b1;
            w_uses_rs1    = 1'b1;
            // only SRLI/SRAI carry a funct7 bit; other I-type immediates alias instr[30]
            w_alu_op      = {(w_funct3 == 3'b101) & bus.if_instr[30], w_funct3};
         end
         OPC_OP: begin
            w_reg_write = 1'b1;
            w_uses_rs1  = 1'b1;
            w_uses_rs2  = 1'b1;
            w_alu_op    = {bus.if_instr[30], w_funct3};
         end
         OPC_FENCE, OPC_SYSTEM: w_imm = '0;
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_rd = w_reg_write ? bus.if_instr[11:7] : '0;

   assign w_hazard = bus.if_valid && r_ex_valid && r_ex_mem_read && (r_ex_rd != '0) &&
                     ((w_uses_rs1 && (w_rs1 == r_ex_rd)) || (w_uses_rs2 && (w_rs2 == r_ex_rd)));

   assign w_take = !bus.flush && bus.if_valid && !w_hazard;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_nxt;
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = ST_RUN;
      if (!bus.flush && bus.stall_in) w_state_nxt = ST_HOLD;
   end

   // FSM: outputs; a stall re-reads the held EX instruction's sources from its first cycle
   always_comb begin
      w_sel_hold = 1'b0;
      w_id_ready = 1'b0;
      if (bus.stall_in && ((r_state == ST_HOLD) || !bus.flush)) w_sel_hold = 1'b1;
      if (!rst) w_id_ready = bus.flush || (!bus.stall_in && !w_hazard);
   end

   // ID/EX pipeline registers and bubble counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid       <= 1'b0;
         r_ex_pc          <= '0;
         r_ex_instr       <= RESET_INSTR;
         r_ex_rd          <= '0;
         r_ex_imm         <= '0;
         r_ex_alu_op      <= '0;
         r_ex_alu_src_imm <= 1'b0;
         r_ex_reg_write   <= 1'b0;
         r_ex_mem_read    <= 1'b0;
         r_ex_mem_write   <= 1'b0;
         r_ex_branch      <= 1'b0;
         r_ex_jump        <= 1'b0;
         r_ex_illegal     <= 1'b0;
         r_perf_bubbles   <= '0;
      end else if (bus.flush || !bus.stall_in) begin
         r_ex_valid       <= w_take;
         r_ex_pc          <= w_take ? bus.if_pc : '0;
         r_ex_instr       <= w_take ? bus.if_instr : RESET_INSTR;
         r_ex_rd          <= w_take ? w_rd : '0;
         r_ex_imm         <= w_take ? w_imm : '0;
         r_ex_alu_op      <= w_take ? w_alu_op : '0;
         r_ex_alu_src_imm <= w_take & w_alu_src_imm;
         r_ex_reg_write   <= w_take & w_reg_write;
         r_ex_mem_read    <= w_take & w_mem_read;
         r_ex_mem_write   <= w_take & w_mem_write;
         r_ex_branch      <= w_take & w_branch;
         r_ex_jump        <= w_take & w_jump;
         r_ex_illegal     <= w_take & w_illegal;
         if (!bus.flush && w_hazard) r_perf_bubbles <= r_perf_bubbles + XLEN'(1);
      end
   end

   assign bus.id_ready       = w_id_ready;
   assign bus.rf_sel_s1      = w_sel_hold ? r_ex_instr[19:15] : w_rs1;
   assign bus.rf_sel_s2      = w_sel_hold ? r_ex_instr[24:20] : w_rs2;
   assign bus.ex_valid       = r_ex_valid;
   assign bus.ex_pc          = r_ex_pc;
   assign bus.ex_instr       = r_ex_instr;
   assign bus.ex_rd          = r_ex_rd;
   assign bus.ex_imm         = r_ex_imm;
   assign bus.ex_alu_op      = r_ex_alu_op;
   assign bus.ex_alu_src_imm = r_ex_alu_src_imm;
   assign bus.ex_reg_write   = r_ex_reg_write;
   assign bus.ex_mem_read    = r_ex_mem_read;
   assign bus.ex_mem_write   = r_ex_mem_write;
   assign bus.ex_branch      = r_ex_branch;
   assign bus.ex_jump        = r_ex_jump;
   assign bus.ex_illegal     = r_ex_illegal;
   assign bus.perf_bubbles   = r_perf_bubbles;
endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: directed instruction stream checked every cycle
// against a behavioural pipeline model, plus literal spot values.
module tb_rv32_decode_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] imm;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic asi, rw, mr, mw, br, jp, il, u1, u2;
   } dec_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   rv32_decode_stage_if bus ();

   rv32_decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Expected decode straight from the opcode table, immediates by arithmetic shifts
   function automatic dec_t decode_m(input logic [31:0] ins);
      dec_t d;
      logic signed [31:0] sx;
      logic [2:0] f3;
      sx = $signed(ins);
      f3 = ins[14:12];
      d = '{imm: 32'd0, op: 4'd0, rd: 5'd0, asi: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0,
            br: 1'b0, jp: 1'b0, il: 1'b0, u1: 1'b0, u2: 1'b0};
      case (ins[6:0])
         7'h37, 7'h17: d.imm = ins & 32'hFFFF_F000;
         7'h6F: begin
            d.imm = 32'((sx >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
                    | (32'(ins[30:21]) << 1);
            d.jp = 1'b1; d.rw = 1'b1;
         end
         7'h67: begin d.imm = 32'(sx >>> 20); d.jp = 1'b1; d.rw = 1'b1; d.u1 = 1'b1; end
         7'h63: begin
            d.imm = 32'((sx >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
                    | (32'(ins[11:8]) << 1);
            d.br = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1;
         end
         7'h03: begin d.imm = 32'(sx >>> 20); d.mr = 1'b1; d.rw = 1'b1; d.u1 = 1'b1; end
         7'h23: begin
            d.imm = 32'((sx >>> 25) << 5) | 32'(ins[11:7]);
            d.mw = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1;
         end
         7'h13: begin
            d.imm = 32'(sx >>> 20); d.asi = 1'b1; d.rw = 1'b1; d.u1 = 1'b1;
            d.op = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
         end
         7'h33: begin d.rw = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; d.op = {ins[30], f3}; end
         7'h0F, 7'h73: d.imm = 32'd0;
         default: d.il = 1'b1;
      endcase
      if (d.rw) d.rd = ins[11:7];
      return d;
   endfunction

   // Model of the ID/EX register contents; m_lvl says how much of it is defined
   dec_t        m_d;
   logic        m_valid, m_hold;
   logic [31:0] m_pc, m_instr, m_bub;
   int          m_lvl;

   function automatic logic hazard_m(input logic v, input logic [31:0] ins);
      dec_t d;
      logic [4:0] s1, s2;
      d  = decode_m(ins);
      s1 = ins[19:15];
      s2 = ins[24:20];
      return v && m_valid && m_d.mr && (m_d.rd != 5'd0) &&
             ((d.u1 && s1 == m_d.rd) || (d.u2 && s2 == m_d.rd));
   endfunction

   always @(posedge clk) begin
      dec_t d;
      logic hz;
      d  = decode_m(bus.if_instr);
      hz = hazard_m(bus.if_valid, bus.if_instr);
      if (rst) begin
         m_d = decode_m(NOP); m_d.asi = 1'b0; m_d.rw = 1'b0; m_d.u1 = 1'b0; m_d.rd = 5'd0;
         m_d.imm = 32'd0; m_valid = 1'b0; m_instr = NOP; m_pc = 32'd0; m_bub = 32'd0;
         m_hold = 1'b0; m_lvl = 3;
      end else if (bus.flush) begin
         m_valid = 1'b0; m_hold = 1'b0; m_lvl = 0;
      end else if (bus.stall_in) begin
         m_hold = 1'b1;
      end else if (hz) begin
         m_d = decode_m(32'h0000_007F); m_d.il = 1'b0;
         m_valid = 1'b0; m_instr = NOP; m_bub = m_bub + 32'd1; m_hold = 1'b0; m_lvl = 2;
      end else if (bus.if_valid) begin
         m_d = d; m_valid = 1'b1; m_instr = bus.if_instr; m_pc = bus.if_pc;
         m_hold = 1'b0; m_lvl = 3;
      end else begin
         m_d = decode_m(32'h0000_007F); m_d.il = 1'b0;
         m_valid = 1'b0; m_hold = 1'b0; m_lvl = 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL cyc%0d %s: got %h want %h", cyc, name, act, exp);
      end
   endtask

   // Compare process: model every cycle, literal pins on selected cycles
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("id_ready", 32'(bus.id_ready),
             32'(!rst && (bus.flush || (!bus.stall_in && !hazard_m(bus.if_valid, bus.if_instr)))));
         if (!bus.stall_in) begin
            chk("rf_sel_s1", 32'(bus.rf_sel_s1), 32'(bus.if_instr[19:15]));
            chk("rf_sel_s2", 32'(bus.rf_sel_s2), 32'(bus.if_instr[24:20]));
         end else if (m_hold && !bus.flush && m_lvl >= 2) begin
            chk("rf_sel_s1_hold", 32'(bus.rf_sel_s1), 32'(m_instr[19:15]));
            chk("rf_sel_s2_hold", 32'(bus.rf_sel_s2), 32'(m_instr[24:20]));
         end
         chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
         chk("perf_bubbles", bus.perf_bubbles, m_bub);
         if (m_lvl >= 1) begin
            chk("flags", 32'({bus.ex_alu_src_imm, bus.ex_reg_write, bus.ex_mem_read,
                              bus.ex_mem_write, bus.ex_branch, bus.ex_jump, bus.ex_illegal}),
                32'({m_d.asi, m_d.rw, m_d.mr, m_d.mw, m_d.br, m_d.jp, m_d.il}));
         end
         if (m_lvl >= 2) begin
            chk("ex_instr", bus.ex_instr, m_instr);
            chk("ex_rd", 32'(bus.ex_rd), 32'(m_d.rd));
         end
         if (m_lvl == 3) begin
            chk("ex_pc", bus.ex_pc, m_pc);
            chk("ex_imm", bus.ex_imm, m_d.imm);
            chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(m_d.op));
         end
         case (cyc)
            1, 2, 26: begin
               chk("L_rst_valid", 32'(bus.ex_valid), 32'd0);
               chk("L_rst_instr", bus.ex_instr, 32'h0000_0013);
               chk("L_rst_perf", bus.perf_bubbles, 32'd0);
               if (cyc != 26) chk("L_rst_ready", 32'(bus.id_ready), 32'd0);
            end
            3: chk("L_ready", 32'(bus.id_ready), 32'd1);
            4: begin
               chk("L_addi_rd", 32'(bus.ex_rd), 32'd1);
               chk("L_addi_imm", bus.ex_imm, 32'd5);
               chk("L_addi_src", 32'(bus.ex_alu_src_imm), 32'd1);
               chk("L_addi_rw", 32'(bus.ex_reg_write), 32'd1);
               chk("L_addi_op", 32'(bus.ex_alu_op), 32'd0);
               chk("L_sw_sel1", 32'(bus.rf_sel_s1), 32'd2);
               chk("L_sw_sel2", 32'(bus.rf_sel_s2), 32'd5);
            end
            5: begin
               chk("L_sw_imm", bus.ex_imm, 32'hFFFF_FFFC);
               chk("L_sw_mw", 32'(bus.ex_mem_write), 32'd1);
               chk("L_sw_rd", 32'(bus.ex_rd), 32'd0);
            end
            6, 17: chk("L_hz_ready", 32'(bus.id_ready), 32'd0);
            7: begin
               chk("L_bub_valid", 32'(bus.ex_valid), 32'd0);
               chk("L_bub_instr", bus.ex_instr, 32'h0000_0013);
               chk("L_bub_perf", bus.perf_bubbles, 32'd1);
            end
            8: chk("L_add_pc", bus.ex_pc, 32'h0000_010C);
            9, 10: begin
               chk("L_hold_sel1", 32'(bus.rf_sel_s1), 32'd2);
               chk("L_hold_sel2", 32'(bus.rf_sel_s2), 32'd2);
               chk("L_hold_rd", 32'(bus.ex_rd), 32'd3);
            end
            12: chk("L_addi4_imm", bus.ex_imm, 32'd7);
            14: chk("L_flush_perf", bus.perf_bubbles, 32'd1);
            15: chk("L_illegal", 32'({bus.ex_illegal, bus.ex_reg_write}), 32'b10);
            18: chk("L_bub2_perf", bus.perf_bubbles, 32'd2);
            20: chk("L_lui_imm", bus.ex_imm, 32'h1234_5000);
            21: chk("L_jal_imm", bus.ex_imm, 32'd8);
            22: chk("L_beq_imm", bus.ex_imm, 32'hFFFF_FFF8);
            23: chk("L_srai_op", 32'(bus.ex_alu_op), 32'hD);
            default: ;
         endcase
      end
   end

   task automatic drv(input logic r, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic st, input logic fl);
      @(posedge clk);
      #2;
      rst = r; bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc;
      bus.stall_in = st; bus.flush = fl;
      cyc++;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0;
      rst = 1'b1; bus.if_valid = 1'b1; bus.if_instr = 32'h0050_0093; bus.if_pc = 32'h100;
      bus.stall_in = 1'b0; bus.flush = 1'b0;
      drv(1, 1, 32'h0050_0093, 32'h100, 0, 0);   // c1 reset
      drv(1, 1, 32'h0050_0093, 32'h100, 0, 0);   // c2 reset
      drv(0, 1, 32'h0050_0093, 32'h100, 0, 0);   // c3 ADDI x1,x0,5
      drv(0, 1, 32'hFE51_2E23, 32'h104, 0, 0);   // c4 SW x5,-4(x2)
      drv(0, 1, 32'h0000_A103, 32'h108, 0, 0);   // c5 LW x2,0(x1)
      drv(0, 1, 32'h0021_01B3, 32'h10C, 0, 0);   // c6 ADD x3,x2,x2 (hazard)
      drv(0, 1, 32'h0021_01B3, 32'h10C, 0, 0);   // c7 ADD held
      for (int i = 0; i < 3; i++)
         drv(0, 1, 32'h0070_0213, 32'h110, 1, 0); // c8-c10 stall, ADDI x4 waiting
      drv(0, 1, 32'h0070_0213, 32'h110, 0, 0);   // c11 release
      drv(0, 1, 32'h0000_A283, 32'h114, 0, 0);   // c12 LW x5,0(x1)
      drv(0, 1, 32'h0002_8333, 32'h118, 1, 1);   // c13 ADD x6,x5,x0 with stall+flush+hazard
      drv(0, 1, 32'h0000_007F, 32'h11C, 0, 0);   // c14 illegal opcode
      drv(0, 0, 32'h0000_0013, 32'h120, 0, 0);   // c15 idle
      drv(0, 1, 32'h0040_2383, 32'h120, 0, 0);   // c16 LW x7,4(x0)
      drv(0, 1, 32'h0070_2023, 32'h124, 0, 0);   // c17 SW x7,0(x0) (rs2 hazard)
      drv(0, 1, 32'h0070_2023, 32'h124, 0, 0);   // c18 SW held
      drv(0, 1, 32'h1234_50B7, 32'h128, 0, 0);   // c19 LUI x1,0x12345
      drv(0, 1, 32'h0080_00EF, 32'h12C, 0, 0);   // c20 JAL x1,8
      drv(0, 1, 32'hFE20_8CE3, 32'h130, 0, 0);   // c21 BEQ x1,x2,-8
      drv(0, 1, 32'h4030_D513, 32'h134, 0, 0);   // c22 SRAI x10,x1,3
      drv(0, 1, 32'h0050_0093, 32'h138, 1, 0);   // c23 stall
      drv(0, 1, 32'h0050_0093, 32'h138, 1, 0);   // c24 stall
      drv(1, 1, 32'h0050_0093, 32'h138, 1, 0);   // c25 reset mid-stall
      drv(0, 0, 32'h0000_0013, 32'h0,   0, 0);   // c26
      drv(0, 1, 32'h0000_0073, 32'h200, 0, 0);   // c27 SYSTEM as NOP
      drv(0, 0, 32'h0000_0013, 32'h0,   0, 0);   // c28
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
